// File: rtl/perf_cnt_reader_pkg.sv
// perf_pkg: shared channel codes, FSM states and default sizes for the counter reader
package perf_pkg;
    localparam int DW_DEFAULT = 32;
    localparam int ND_DEFAULT = 10;
    localparam logic [1:0] CH_TOTAL   = 2'd0;
    localparam logic [1:0] CH_J       = 2'd1;
    localparam logic [1:0] CH_JS      = 2'd2;
    localparam logic [1:0] CH_LOADUSE = 2'd3;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONV,
        ST_PRESENT
    } state_e;
endpackage

// File: rtl/perf_cnt_reader_if.sv
// perf_cnt_reader_if: valid/ready result stream carrying channel id and packed BCD
interface perf_cnt_reader_if #(parameter int ND = 10);
    logic            out_valid;
    logic [1:0]      out_channel;
    logic [4*ND-1:0] out_bcd;
    logic            in_ready;
    modport master (output out_valid, output out_channel, output out_bcd, input in_ready);
    modport slave  (input out_valid, input out_channel, input out_bcd, output in_ready);
endinterface

// File: rtl/perf_cnt_reader_bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 binary to packed BCD, one bit per cycle
module bin2bcd_seq
    import perf_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int ND = ND_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DW-1:0]   bin,
    output logic            done,
    output logic [4*ND-1:0] bcd
);
    localparam int CW = $clog2(DW + 1);
    logic [DW-1:0]   sh_q, sh_d;
    logic [4*ND-1:0] acc_q, acc_d, adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d, done_q, done_d;

    // Digit correction, then one shift step per cycle; done pulses the cycle after the last shift
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < ND; i++)
            adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
        sh_d   = sh_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            sh_d  = bin;
            acc_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            {acc_d, sh_d} = {adj, sh_q} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DW - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Converter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = acc_q;
endmodule

// File: rtl/perf_cnt_reader.sv
// perf_cnt_reader: snapshots four perf counters and streams each as packed BCD
module perf_cnt_reader
    import perf_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int ND = ND_DEFAULT
) (
    input  logic          in_CLK,
    input  logic          in_RST_N,
    input  logic          in_SNAP,
    input  logic [DW-1:0] in_total,
    input  logic [DW-1:0] in_J,
    input  logic [DW-1:0] in_JS,
    input  logic [DW-1:0] in_loaduse,
    output logic          out_busy,
    output logic          out_overrun,
    perf_cnt_reader_if.master res
);
    state_e                 state_q, state_d;
    logic [3:0][DW-1:0]     shadow_q, shadow_d;
    logic [1:0]             ch_q, ch_d;
    logic [4*ND-1:0]        bcd_q, bcd_d, conv_bcd;
    logic                   overrun_q, overrun_d;
    logic                   conv_start, conv_done;

    bin2bcd_seq #(.DW(DW), .ND(ND)) u_conv (
        .clk   (in_CLK),
        .rst_n (in_RST_N),
        .start (conv_start),
        .bin   (shadow_q[ch_q]),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Sequencer: snapshot, convert each channel in turn, hold result until accepted
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        ch_d       = ch_q;
        bcd_d      = bcd_q;
        conv_start = 1'b0;
        overrun_d  = in_SNAP && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: if (in_SNAP) begin
                shadow_d = {in_loaduse, in_JS, in_J, in_total};
                ch_d     = CH_TOTAL;
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                conv_start = 1'b1;
                state_d    = ST_CONV;
            end
            ST_CONV: if (conv_done) begin
                bcd_d   = conv_bcd;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: if (res.in_ready) begin
                state_d = (ch_q == CH_LOADUSE) ? ST_IDLE : ST_LOAD;
                ch_d    = (ch_q == CH_LOADUSE) ? ch_q : ch_q + 2'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset abandons any conversion in flight
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            ch_q      <= CH_TOTAL;
            bcd_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            ch_q      <= ch_d;
            bcd_q     <= bcd_d;
            overrun_q <= overrun_d;
        end
    end

    assign res.out_valid   = (state_q == ST_PRESENT);
    assign res.out_channel = ch_q;
    assign res.out_bcd     = bcd_q;
    assign out_busy        = (state_q != ST_IDLE);
    assign out_overrun     = overrun_q;
endmodule

// File: tb/tb_perf_cnt_reader.sv
// tb_perf_cnt_reader: directed and random checks of the counter reader against a decimal model
module tb_perf_cnt_reader;
    localparam int DW = 32;
    localparam int ND = 10;
    typedef struct packed {
        logic [1:0]      ch;
        logic [4*ND-1:0] bcd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          snap = 1'b0;
    logic [DW-1:0] v_total = '0, v_j = '0, v_js = '0, v_lu = '0;
    logic          busy, overrun;
    int            checks = 0, errors = 0, cyc = 0, ref_cyc = 0;
    exp_t          q[$];

    perf_cnt_reader_if #(.ND(ND)) res ();

    perf_cnt_reader #(.DW(DW), .ND(ND)) dut (
        .in_CLK      (clk),
        .in_RST_N    (rst_n),
        .in_SNAP     (snap),
        .in_total    (v_total),
        .in_J        (v_j),
        .in_JS       (v_js),
        .in_loaduse  (v_lu),
        .out_busy    (busy),
        .out_overrun (overrun),
        .res         (res)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [4*ND-1:0] to_bcd(input logic [DW-1:0] v);
        logic [4*ND-1:0] r = '0;
        longint unsigned x = longint'(v);
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [4*ND-1:0] b);
        logic ok = 1'b1;
        for (int i = 0; i < ND; i++)
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [DW-1:0] rnd_val();
        int unsigned p = 1;
        int k;
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: begin
                k = $urandom_range(0, 9);
                for (int i = 0; i < k; i++) p = p * 10;
                return DW'(p - $urandom_range(0, 1));
            end
            3: return DW'($urandom_range(0, 99999));
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_snap(input logic [DW-1:0] t, input logic [DW-1:0] j,
                           input logic [DW-1:0] js, input logic [DW-1:0] lu);
        v_total = t; v_j = j; v_js = js; v_lu = lu;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        ref_cyc = cyc;
        q.push_back('{ch: 2'd0, bcd: to_bcd(t)});
        q.push_back('{ch: 2'd1, bcd: to_bcd(j)});
        q.push_back('{ch: 2'd2, bcd: to_bcd(js)});
        q.push_back('{ch: 2'd3, bcd: to_bcd(lu)});
        v_total = $urandom; v_j = $urandom; v_js = $urandom; v_lu = $urandom;
        check("snap_no_overrun", overrun, 0);
        check("snap_busy", busy, 1);
    endtask

    task automatic expect_beat(input int lat, input int hold, input bit snap_hs);
        int   n = 0;
        exp_t e;
        while (!res.out_valid && n < 200) begin
            tick();
            n++;
        end
        check("valid_seen", res.out_valid, 1);
        if (lat >= 0) check("latency", cyc - ref_cyc, lat);
        check("sb_nonempty", q.size() != 0, 1);
        e = (q.size() != 0) ? q.pop_front() : '0;
        check("channel", res.out_channel, e.ch);
        check("bcd", res.out_bcd, e.bcd);
        check("digits_le9", digits_ok(res.out_bcd), 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", res.out_valid, 1);
            check("hold_channel", res.out_channel, e.ch);
            check("hold_bcd", res.out_bcd, e.bcd);
        end
        res.in_ready = 1'b1;
        snap = snap_hs;
        tick();
        res.in_ready = 1'b0;
        snap = 1'b0;
        ref_cyc = cyc;
        check("valid_drop", res.out_valid, 0);
        check("hs_overrun", overrun, snap_hs);
    endtask

    initial begin
        int seen;
        res.in_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", res.out_valid, 0);
        check("rst_channel", res.out_channel, 0);
        check("rst_bcd", res.out_bcd, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", busy, 0);

        do_snap(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd10);
        for (int i = 0; i < 4; i++) expect_beat(34, 0, 1'b0);
        check("seq_done_idle", busy, 0);

        do_snap(32'd7, 32'd65536, 32'd999999999, 32'd1000000000);
        expect_beat(34, 0, 1'b0);
        expect_beat(34, 20, 1'b0);
        expect_beat(34, 0, 1'b0);
        expect_beat(34, 0, 1'b0);

        do_snap(32'd42, 32'd4000000000, 32'd5, 32'd123456789);
        repeat (10) tick();
        v_total = 99; v_j = 99; v_js = 99; v_lu = 99;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        check("mid_overrun_pulse", overrun, 1);
        tick();
        check("mid_overrun_end", overrun, 0);
        for (int i = 0; i < 4; i++) expect_beat(34, 0, 1'b0);

        do_snap(32'd11, 32'd22, 32'd33, 32'd44);
        expect_beat(34, 0, 1'b0);
        expect_beat(34, 0, 1'b0);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", res.out_valid, 0);
        check("arst_channel", res.out_channel, 0);
        check("arst_bcd", res.out_bcd, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        q.delete();
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (res.out_valid || busy) seen++;
        end
        check("no_work_after_rst", seen, 0);

        do_snap(32'd5, 32'd6, 32'd7, 32'd8);
        for (int i = 0; i < 3; i++) expect_beat(34, 0, 1'b0);
        expect_beat(34, 0, 1'b1);
        check("final_hs_idle", busy, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (res.out_valid || busy) seen++;
        end
        check("final_hs_snap_ignored", seen, 0);

        do_snap(32'd100, 32'd200, 32'd300, 32'd400);
        for (int i = 0; i < 4; i++) expect_beat(34, 0, 1'b0);
        do_snap(32'd9, 32'd99, 32'd999, 32'd9999);
        for (int i = 0; i < 4; i++) expect_beat(34, 0, 1'b0);

        for (int s = 0; s < 150; s++) begin
            do_snap(rnd_val(), rnd_val(), rnd_val(), rnd_val());
            for (int i = 0; i < 4; i++) expect_beat(34, $urandom_range(0, 2), 1'b0);
        end
        check("sb_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
